stats_arb: RTL and testbench
============================

Name: stats_arb

Overview:
- Merges the stat increment streams of up to PORTS statistics collectors onto one shared stat-counter update interface, using a round-robin arbiter with a registered output stage.
- Also sequences the collectors' flush requests: one update request fans out as per-port update pulses, staggered so that collectors do not all flush in the same burst.
- Sits between the per-subsystem collectors and the single statistics counter block.

Parameters:
- PORTS, 4, number of collector input streams (2..16)
- STAT_INC_WIDTH, 16, increment data width
- STAT_ID_WIDTH, 8, counter ID width; IDs pass through unchanged because collectors already apply their own base ID
- UPDATE_STAGGER, 16, cycles between successive per-port update pulses (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- s_axis_stat_tdata  in  PORTS*STAT_INC_WIDTH  per-port increment
- s_axis_stat_tid  in  PORTS*STAT_ID_WIDTH  per-port counter ID
- s_axis_stat_tvalid  in  PORTS  per-port valid
- s_axis_stat_tready  out  PORTS  per-port ready
- m_axis_stat_tdata  out  STAT_INC_WIDTH  merged increment
- m_axis_stat_tid  out  STAT_ID_WIDTH  merged counter ID
- m_axis_stat_tvalid  out  1  merged valid
- m_axis_stat_tready  in  1  merged ready
- update  in  1  single-cycle flush request
- update_out  out  PORTS  per-port flush pulse, driven to each collector's update input
- busy  out  1  high while an update sequence is active or pending

Behaviour:
- Reset (rst_n low, asynchronous):
  - m_axis_stat_tvalid=0, tdata=0, tid=0, s_axis_stat_tready=0, update_out=0, busy=0.
  - Round-robin pointer set so that port 0 has highest priority.
  - Stagger sequencer idle, pending flag cleared.
- Output register:
  - Load enable is ld = !m_tvalid || m_tready.
  - When ld is high and some s_tvalid is high, grant one port. Set s_tready[grant]=1 combinationally; all other readies stay 0. Capture that port's tdata/tid and set m_tvalid=1 on the next edge.
  - When ld is high and no request is present, m_tvalid goes to 0 on the next edge.
  - Latency is 1 cycle from input acceptance to output valid. Sustained throughput is 1 transfer per cycle with m_tready held high.
  - While m_tvalid=1 and m_tready=0, tdata and tid are stable and every s_tready is 0.
- Arbitration:
  - Round-robin. The search starts at the port after the last granted port and wraps from PORTS-1 to 0.
  - The pointer updates only on an actual grant.
  - Any set of simultaneous requests is served one port per cycle, in order. No port waits more than PORTS-1 grants.
- No data modification:
  - Zero-valued increments are passed through.
  - The arbiter never sums increments or alters IDs.
- Update sequencer (states IDLE, RUN):
  - IDLE: when update=1, go to RUN. Pulse update_out[0] on the next cycle, then update_out[i] at UPDATE_STAGGER*i cycles after update_out[0].
  - Each update_out bit is high for exactly 1 cycle.
  - RUN ends after update_out[PORTS-1] pulses. The sequencer then returns to IDLE, or starts a new sequence if pending=1.
  - update=1 during RUN sets pending; multiple requests coalesce into one. The sequence in progress is never restarted.
  - busy = (state==RUN) || pending.
  - Stagger counter width is $clog2(UPDATE_STAGGER+1); port index width is $clog2(PORTS).
- Reset mid-sequence or mid-transfer:
  - All state clears immediately; any in-flight output word is dropped.
  - No update_out pulse occurs after reset is released until a new update arrives.
- Parameter assertions:
  - Error if PORTS<2.
  - Error if UPDATE_STAGGER<1.

Decomposition:
- Shared stats package holds:
  - the sequencer state encoding (IDLE/RUN);
  - helper width constants: port index width and stagger counter width.
- One sub-module is natural: stats_rr_arb, a combinational-grant round-robin arbiter with a registered pointer. It is PORTS wide, takes request and advance-enable inputs, and outputs a one-hot grant plus an encoded grant index.
- The stats_arb top contains the output register and the update sequencer.

Test Plan:
- Single port: port 2 presents tdata=0x0005, tid=0x12, m_tready=1 -> s_tready[2] high that cycle; next cycle m_tvalid=1, tdata=0x0005, tid=0x12.
- All 4 ports valid continuously, m_tready=1 -> output tids cycle port0,1,2,3,0,... one per cycle, with no gaps.
- Backpressure: m_tready=0 for 5 cycles while port 1 is valid -> output is held stable, all s_tready=0; the word is delivered the cycle m_tready rises and no input word is lost or duplicated.
- update pulse at cycle T, UPDATE_STAGGER=16, PORTS=4 -> update_out[0..3] single-cycle pulses at T+1, T+17, T+33, T+49; busy=1 from T+1 through T+49.
- Two more update pulses at T+10 and T+20 -> exactly one further sequence, starting at T+50 (update_out[0]).
- rst_n asserted at T+20, mid-sequence and with m_tvalid=1 -> m_tvalid and update_out drop asynchronously; no later pulses occur; after release, port 0 is granted first when all ports request.

Source files
------------

// File: rtl/stats_pkg.sv
// Shared definitions for the statistics arbiter: sequencer state encoding and
// width helpers used by the top and the round-robin arbiter.
package stats_pkg;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  // Index width for a PORTS-wide vector; never narrower than one bit.
  function automatic int port_idx_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  function automatic int stagger_cnt_width(input int stagger);
    return $clog2(stagger + 1);
  endfunction

endpackage

// File: rtl/stats_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from the port after
// the last granted one; the pointer only moves on an accepted grant.
module stats_rr_arb
  import stats_pkg::*;
#(
  parameter int PORTS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PORTS-1:0]                  req,
  input  logic                              advance,
  output logic [PORTS-1:0]                  grant,
  output logic [port_idx_width(PORTS)-1:0]  grant_idx,
  output logic                              grant_valid
);

  localparam int IDX_W = port_idx_width(PORTS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(PORTS - 1);

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= PORTS; k++) begin
      cand = int'(last) + k;
      if (cand >= PORTS) begin
        cand = cand - PORTS;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid     = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  // Resetting to the highest port makes port 0 the first candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= LAST_PORT;
    end else if (advance && grant_valid) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/stats_arb.sv
// Merges per-collector stat increment streams onto one registered output and
// fans a single flush request out as staggered per-port update pulses.
module stats_arb
  import stats_pkg::*;
#(
  parameter int PORTS          = 4,
  parameter int STAT_INC_WIDTH = 16,
  parameter int STAT_ID_WIDTH  = 8,
  parameter int UPDATE_STAGGER = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PORTS*STAT_INC_WIDTH-1:0]   s_axis_stat_tdata,
  input  logic [PORTS*STAT_ID_WIDTH-1:0]    s_axis_stat_tid,
  input  logic [PORTS-1:0]                  s_axis_stat_tvalid,
  output logic [PORTS-1:0]                  s_axis_stat_tready,
  output logic [STAT_INC_WIDTH-1:0]         m_axis_stat_tdata,
  output logic [STAT_ID_WIDTH-1:0]          m_axis_stat_tid,
  output logic                              m_axis_stat_tvalid,
  input  logic                              m_axis_stat_tready,
  input  logic                              update,
  output logic [PORTS-1:0]                  update_out,
  output logic                              busy
);

  localparam int IDX_W = port_idx_width(PORTS);
  localparam int CNT_W = stagger_cnt_width(UPDATE_STAGGER);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(PORTS - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(UPDATE_STAGGER - 1);

  if (PORTS < 2) begin : g_bad_ports
    $error("stats_arb: PORTS must be at least 2");
  end
  if (UPDATE_STAGGER < 1) begin : g_bad_stagger
    $error("stats_arb: UPDATE_STAGGER must be at least 1");
  end

  logic                      ld;
  logic [PORTS-1:0]          grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_valid;
  logic [STAT_INC_WIDTH-1:0] sel_data;
  logic [STAT_ID_WIDTH-1:0]  sel_id;

  assign ld = !m_axis_stat_tvalid || m_axis_stat_tready;

  stats_rr_arb #(
    .PORTS(PORTS)
  ) u_rr_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (s_axis_stat_tvalid),
    .advance     (ld),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Ready is held low while reset is asserted, even though ld is high then.
  assign s_axis_stat_tready = (ld && rst_n) ? grant : '0;

  always_comb begin
    sel_data = '0;
    sel_id   = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_idx == IDX_W'(p)) begin
        sel_data = s_axis_stat_tdata[p*STAT_INC_WIDTH +: STAT_INC_WIDTH];
        sel_id   = s_axis_stat_tid[p*STAT_ID_WIDTH +: STAT_ID_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_stat_tvalid <= 1'b0;
      m_axis_stat_tdata  <= '0;
      m_axis_stat_tid    <= '0;
    end else if (ld) begin
      if (grant_valid) begin
        m_axis_stat_tvalid <= 1'b1;
        m_axis_stat_tdata  <= sel_data;
        m_axis_stat_tid    <= sel_id;
      end else begin
        m_axis_stat_tvalid <= 1'b0;
      end
    end
  end

  seq_state_t       state;
  logic             pending;
  logic [IDX_W-1:0] port_cnt;
  logic [IDX_W-1:0] next_port;
  logic [CNT_W-1:0] stag_cnt;

  assign next_port = port_cnt + 1'b1;
  assign busy      = (state == SEQ_RUN) || pending;

  // A request arriving during the final pulse is folded into the restart,
  // otherwise it would be stranded as a pending flag in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEQ_IDLE;
      pending    <= 1'b0;
      port_cnt   <= '0;
      stag_cnt   <= '0;
      update_out <= '0;
    end else begin
      update_out <= '0;
      case (state)
        SEQ_IDLE: begin
          if (update) begin
            state         <= SEQ_RUN;
            pending       <= 1'b0;
            port_cnt      <= '0;
            stag_cnt      <= '0;
            update_out[0] <= 1'b1;
          end
        end
        SEQ_RUN: begin
          if (update) begin
            pending <= 1'b1;
          end
          if (port_cnt == LAST_PORT) begin
            if (pending || update) begin
              pending       <= 1'b0;
              port_cnt      <= '0;
              stag_cnt      <= '0;
              update_out[0] <= 1'b1;
            end else begin
              state <= SEQ_IDLE;
            end
          end else if (stag_cnt == STAG_LAST) begin
            stag_cnt              <= '0;
            port_cnt              <= next_port;
            update_out[next_port] <= 1'b1;
          end else begin
            stag_cnt <= stag_cnt + 1'b1;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stats_arb.sv
// Directed bench for stats_arb: arbitration order, backpressure, staggered
// update sequencing, request coalescing and asynchronous reset.
module tb_stats_arb;

  localparam int P = 4;
  localparam int W = 16;
  localparam int I = 8;
  localparam int S = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [P*W-1:0]   s_tdata;
  logic [P*I-1:0]   s_tid;
  logic [P-1:0]     s_tvalid;
  logic [P-1:0]     s_tready;
  logic [W-1:0]     m_tdata;
  logic [I-1:0]     m_tid;
  logic             m_tvalid;
  logic             m_tready;
  logic             update;
  logic [P-1:0]     update_out;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stats_arb #(
    .PORTS(P), .STAT_INC_WIDTH(W), .STAT_ID_WIDTH(I), .UPDATE_STAGGER(S)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis_stat_tdata  (s_tdata),
    .s_axis_stat_tid    (s_tid),
    .s_axis_stat_tvalid (s_tvalid),
    .s_axis_stat_tready (s_tready),
    .m_axis_stat_tdata  (m_tdata),
    .m_axis_stat_tid    (m_tid),
    .m_axis_stat_tvalid (m_tvalid),
    .m_axis_stat_tready (m_tready),
    .update             (update),
    .update_out         (update_out),
    .busy               (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [W-1:0] d, input logic [I-1:0] id,
                          input logic v);
    s_tdata[p*W +: W] = d;
    s_tid[p*I +: I]   = id;
    s_tvalid[p]       = v;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    m_tready = 1'b1;
    update   = 1'b1;
    for (int p = 0; p < P; p++) set_port(p, 16'h1111, 8'h11, 1'b1);
    tick();
    tick();
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tid !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_out: got v=%b d=%h id=%h required 0/0/0", m_tvalid, m_tdata, m_tid);
    end
    n_checks++;
    if (s_tready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b required 0000", s_tready);
    end
    n_checks++;
    if (update_out !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_seq: got upd=%b busy=%b required 0000/0", update_out, busy);
    end
    update = 1'b0;
    for (int p = 0; p < P; p++) set_port(p, '0, '0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_port;
    m_tready = 1'b1;
    set_port(2, 16'h0005, 8'h12, 1'b1);
    #1;
    n_checks++;
    if (s_tready !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL single_ready: got %b required 0100", s_tready);
    end
    tick();
    set_port(2, '0, '0, 1'b0);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h0005 || m_tid !== 8'h12) begin
      n_fail++;
      $display("[TB] FAIL single_out: got v=%b d=%h id=%h required 1/0005/12", m_tvalid, m_tdata, m_tid);
    end
    tick();
    n_checks++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_drain: got v=%b required 0", m_tvalid);
    end
  endtask

  // Last grant was port 2, so service continues at port 3 and wraps.
  task automatic test_round_robin;
    logic [W-1:0] exp_d;
    int           exp_p;
    m_tready = 1'b1;
    for (int p = 0; p < P; p++)
      set_port(p, (p == 0) ? 16'h0000 : 16'(16'h0100 + p), 8'(8'h10 + p), 1'b1);
    #1;
    n_checks++;
    if (s_tready !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL rr_first_ready: got %b required 1000", s_tready);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) for (int p = 0; p < P; p++) set_port(p, '0, '0, 1'b0);
      exp_p = (3 + i) % 4;
      exp_d = (exp_p == 0) ? 16'h0000 : 16'(16'h0100 + exp_p);
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tid !== 8'(8'h10 + exp_p) || m_tdata !== exp_d) begin
        n_fail++;
        $display("[TB] FAIL rr_word%0d: got v=%b id=%h d=%h required 1/%h/%h",
                 i, m_tvalid, m_tid, m_tdata, 8'(8'h10 + exp_p), exp_d);
      end
    end
    tick();
    n_checks++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rr_drain: got v=%b required 0", m_tvalid);
    end
  endtask

  task automatic test_backpressure;
    m_tready = 1'b0;
    set_port(1, 16'hAAAA, 8'h21, 1'b1);
    #1;
    n_checks++;
    if (s_tready !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL bp_accept: got %b required 0010", s_tready);
    end
    tick();
    set_port(1, 16'hBBBB, 8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (s_tready !== 4'b0000 || m_tvalid !== 1'b1 || m_tdata !== 16'hAAAA || m_tid !== 8'h21) begin
        n_fail++;
        $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b d=%h id=%h required 0000/1/AAAA/21",
                 i, s_tready, m_tvalid, m_tdata, m_tid);
      end
      tick();
    end
    m_tready = 1'b1;
    #1;
    n_checks++;
    if (s_tready !== 4'b0010 || m_tdata !== 16'hAAAA) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got rdy=%b d=%h required 0010/AAAA", s_tready, m_tdata);
    end
    tick();
    set_port(1, '0, '0, 1'b0);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'hBBBB || m_tid !== 8'h22) begin
      n_fail++;
      $display("[TB] FAIL bp_next: got v=%b d=%h id=%h required 1/BBBB/22", m_tvalid, m_tdata, m_tid);
    end
    tick();
    n_checks++;
    if (m_tvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_drain: got v=%b required 0", m_tvalid);
    end
  endtask

  // Cycle n counts from the update request; pulses land at 1 + S*port.
  task automatic test_update_sequence;
    logic [P-1:0] exp_u;
    logic         exp_b;
    update = 1'b1;
    tick();
    update = 1'b0;
    for (int n = 1; n <= 52; n++) begin
      exp_u = '0;
      for (int b = 0; b < P; b++) if (n == 1 + S*b) exp_u[b] = 1'b1;
      exp_b = (n <= 49);
      n_checks++;
      if (update_out !== exp_u || busy !== exp_b) begin
        n_fail++;
        $display("[TB] FAIL upd_seq_n%0d: got upd=%b busy=%b required %b/%b", n, update_out, busy, exp_u, exp_b);
      end
      tick();
    end
  endtask

  task automatic test_coalesce;
    logic [P-1:0] exp_u;
    logic         exp_b;
    update = 1'b1;
    tick();
    for (int n = 1; n <= 101; n++) begin
      update = (n == 10 || n == 20);
      exp_u  = '0;
      for (int b = 0; b < P; b++) if (n == 1 + S*b || n == 50 + S*b) exp_u[b] = 1'b1;
      exp_b = (n <= 98);
      n_checks++;
      if (update_out !== exp_u || busy !== exp_b) begin
        n_fail++;
        $display("[TB] FAIL coalesce_n%0d: got upd=%b busy=%b required %b/%b", n, update_out, busy, exp_u, exp_b);
      end
      tick();
    end
    update = 1'b0;
  endtask

  task automatic test_reset_mid;
    int bad;
    m_tready = 1'b0;
    set_port(3, 16'h3333, 8'h33, 1'b1);
    update = 1'b1;
    tick();
    update = 1'b0;
    set_port(3, '0, '0, 1'b0);
    for (int n = 2; n <= 17; n++) tick();
    n_checks++;
    if (update_out !== 4'b0010 || m_tvalid !== 1'b1 || m_tdata !== 16'h3333) begin
      n_fail++;
      $display("[TB] FAIL mid_before: got upd=%b v=%b d=%h required 0010/1/3333", update_out, m_tvalid, m_tdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || update_out !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_async: got v=%b d=%h upd=%b busy=%b required 0/0/0000/0",
               m_tvalid, m_tdata, update_out, busy);
    end
    m_tready = 1'b1;
    for (int p = 0; p < P; p++) set_port(p, 16'(16'h0400 + p), 8'(8'h40 + p), 1'b1);
    #1;
    n_checks++;
    if (s_tready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL mid_rst_ready: got %b required 0000", s_tready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (s_tready !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL post_rst_grant: got %b required 0001", s_tready);
    end
    tick();
    for (int p = 0; p < P; p++) set_port(p, '0, '0, 1'b0);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tid !== 8'h40 || m_tdata !== 16'h0400) begin
      n_fail++;
      $display("[TB] FAIL post_rst_word: got v=%b id=%h d=%h required 1/40/0400", m_tvalid, m_tid, m_tdata);
    end
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      if (update_out !== 4'b0000 || busy !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL post_rst_quiet: got %0d active cycles required 0", bad);
    end
  endtask

  initial begin
    s_tdata  = '0;
    s_tid    = '0;
    s_tvalid = '0;
    m_tready = 1'b0;
    update   = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_update_sequence();
    test_coalesce();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
